ex_mem: RTL
===========

# ex_mem

Pipeline register between the execute (EX) and memory (MEM) stages of the CPU core. It latches the EX results: register writeback, HI/LO multiply result and flags. It applies the per-stage stall vector and the pipeline flush. It also carries the two-cycle multiply-accumulate intermediate state (64-bit partial result plus cycle counter) back to EX while EX is stalled.

## Interface
- No parameters. Widths: RegBus = 32, RegAddrBus = 5, stall vector = 6 bits (bit 0 = PC … bit 5 = WB).
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- stall  in  6  per-stage stall request; this block uses stall[3] (EX) and stall[4] (MEM)
- flush  in  1  exception/branch flush; kills the instruction entering MEM
- ex_wd  in  5  destination register address
- ex_wreg  in  1  register write enable
- ex_wdata  in  32  register write data
- ex_hi, ex_lo  in  32 each  HI/LO write data
- ex_whilo  in  1  HI/LO write enable
- ex_flags  in  32  flags register value
- hilo_temp_i  in  64  MADD/MSUB partial product from EX
- cnt_i  in  2  MADD/MSUB cycle count from EX
- mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_flags  out  5/1/32/32/32/1/32  registered copies presented to MEM
- hilo_temp_o  out  64  partial product returned to EX
- cnt_o  out  2  cycle count returned to EX

## Operation
- All outputs are registers updated on the rising edge of clk only. There are no combinational paths from input to output.
- Per-edge priority, highest first:
  1. rst = 1: all outputs take their reset value (below).
  2. flush = 1: MEM outputs become a bubble; hilo_temp_o and cnt_o are cleared to 0.
  3. stall[3] = 1 and stall[4] = 0: MEM outputs become a bubble; hilo_temp_o ← hilo_temp_i and cnt_o ← cnt_i. This captures the accumulate state for the next EX cycle.
  4. stall[3] = 0: MEM outputs ← EX inputs; hilo_temp_o and cnt_o are cleared to 0.
  5. stall[3] = 1 and stall[4] = 1: every output holds its value.
- Bubble: mem_wd = 0, mem_wreg = 0, mem_wdata = 0, mem_hi = 0, mem_lo = 0, mem_whilo = 0, mem_flags = 0.
- Reset value: every output is 0. This equals the bubble, with temp and count also at 0.
- The stall pattern stall[3] = 0 with stall[4] = 1 is illegal (a stage may not advance into a stalled stage). The block treats it as case 4. The bench flags it with an assertion.
- The MADD/MSUB sequence, as owned by EX:
  - Cycle 1: EX raises stall[3], drives cnt_i = 1 and the 64-bit product on hilo_temp_i.
  - Cycle 2: EX reads cnt_o = 1 and hilo_temp_o, adds to or subtracts from {HI, LO}, drives cnt_i = 2 and drops stall[3].
  - This block stores and returns the state only. It performs no arithmetic.
- No width conversion; every field is copied bit-exact.

## Timing
- Latency is one cycle from EX inputs to mem_* outputs.
- The counter round trip is one cycle: a value on cnt_i at edge N (stall case 3) appears on cnt_o after edge N and is visible to EX during cycle N+1.
- Flush takes effect on the same edge it is sampled. A flush that coincides with stall[3] = 1 still clears the accumulate state, which aborts the MADD.
- Reset that arrives mid-MADD (cnt_o = 1) clears cnt_o to 0 on that edge.
- Throughput is one instruction per cycle when stall = 0.

## Test plan
- Reset: drive all inputs to non-zero (ex_wdata = 0xDEADBEEF, cnt_i = 1) with rst = 1 for 2 cycles → every output is 0 after each edge.
- Pass-through: stall = 0, ex_wd = 5'd3, ex_wreg = 1, ex_wdata = 0x12345678, ex_hi = 0xA, ex_lo = 0xB, ex_whilo = 1, ex_flags = 0x4 → identical values on mem_* one edge later; cnt_o = 0.
- EX stall bubble plus accumulate capture: stall = 6'b001111, hilo_temp_i = 0x0000_0001_FFFF_FFFE, cnt_i = 1 → mem_wreg = 0, mem_whilo = 0, hilo_temp_o = 0x0000_0001_FFFF_FFFE, cnt_o = 1. On the next edge with stall = 0 → cnt_o = 0 and the EX values pass through.
- Hold: load the pass-through values, then apply stall = 6'b011111 for 3 cycles while changing all inputs → mem_* and cnt_o remain unchanged.
- Flush priority: stall = 6'b001111, cnt_i = 1, flush = 1 → bubble on mem_*, cnt_o = 0, hilo_temp_o = 0.
- Back-to-back: four instructions with distinct ex_wd values 1..4 and stall = 0 → mem_wd sequence 1, 2, 3, 4 on consecutive edges with no gaps.

Source files
------------

// File: rtl/ex_mem.sv
// ex_mem: EX -> MEM pipeline register.
// Latches the EX results (register writeback, HI/LO, flags) toward MEM, applies
// the stall/flush controls, and returns the MADD/MSUB partial product and cycle
// count to EX while EX is stalled.
module ex_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic        ex_whilo,
    input  logic [31:0] ex_flags,
    input  logic [63:0] hilo_temp_i,
    input  logic [1:0]  cnt_i,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        mem_whilo,
    output logic [31:0] mem_flags,
    output logic [63:0] hilo_temp_o,
    output logic [1:0]  cnt_o
);

    // Everything that travels on to MEM. An all-zero value is a bubble.
    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic [31:0] flags;
    } mem_t;

    mem_t        ex_bundle;
    mem_t        mem_d, mem_q;
    logic [63:0] hilo_temp_d, hilo_temp_q;
    logic [1:0]  cnt_d, cnt_q;
    logic        stall_ex, stall_mem;

    // Only the EX and MEM stall bits matter here; the rest are ignored.
    logic        unused_stall_bits;
    assign unused_stall_bits = ^{stall[5], stall[2:0]};

    assign stall_ex  = stall[3];
    assign stall_mem = stall[4];

    // Gather the EX inputs into one bundle.
    always_comb begin
        ex_bundle       = '0;
        ex_bundle.wd    = ex_wd;
        ex_bundle.wreg  = ex_wreg;
        ex_bundle.wdata = ex_wdata;
        ex_bundle.hi    = ex_hi;
        ex_bundle.lo    = ex_lo;
        ex_bundle.whilo = ex_whilo;
        ex_bundle.flags = ex_flags;
    end

    // Next-state selection: flush, then EX-only stall (bubble and capture the
    // accumulate state), then advance. When both EX and MEM stall, nothing
    // changes. The illegal pattern (EX advancing into a stalled MEM) falls into
    // the advance branch.
    always_comb begin
        mem_d       = mem_q;
        hilo_temp_d = hilo_temp_q;
        cnt_d       = cnt_q;
        if (flush) begin
            mem_d       = '0;
            hilo_temp_d = '0;
            cnt_d       = '0;
        end else if (stall_ex && !stall_mem) begin
            mem_d       = '0;
            hilo_temp_d = hilo_temp_i;
            cnt_d       = cnt_i;
        end else if (!stall_ex) begin
            mem_d       = ex_bundle;
            hilo_temp_d = '0;
            cnt_d       = '0;
        end
    end

    // State registers; reset is the same as a bubble with the accumulate state
    // cleared, so a reset mid-MADD aborts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q       <= '0;
            hilo_temp_q <= '0;
            cnt_q       <= '0;
        end else begin
            mem_q       <= mem_d;
            hilo_temp_q <= hilo_temp_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_wd      = mem_q.wd;
    assign mem_wreg    = mem_q.wreg;
    assign mem_wdata   = mem_q.wdata;
    assign mem_hi      = mem_q.hi;
    assign mem_lo      = mem_q.lo;
    assign mem_whilo   = mem_q.whilo;
    assign mem_flags   = mem_q.flags;
    assign hilo_temp_o = hilo_temp_q;
    assign cnt_o       = cnt_q;

endmodule
